// File: rtl/aurora_pkg.sv
// Shared definitions for the barrel pipeline: thread count, width defaults and the
// host-port FSM states used by the memory stage.
package aurora_pkg;
   localparam int NUM_THREADS            = 4;
   localparam int THREAD_ID_W            = 2;
   localparam int PROC_DATA_WIDTH        = 64;
   localparam int PROC_REGFILE_LOG2_DEEP = 5;
   localparam int INSTMEM_LOG2_DEEP      = 8;
   localparam int DMEM_LOG2_DEEP         = 8;

   typedef enum logic {
      HOST_IDLE = 1'b0,
      HOST_RESP = 1'b1
   } host_state_e;
endpackage

// File: rtl/mem_stage_if.sv
// Host/debug access port of the memory stage: request/grant handshake plus read response.
// master = host side, slave = mem_stage side.
interface mem_stage_if
   import aurora_pkg::*;
#(
   parameter int PDW = PROC_DATA_WIDTH,
   parameter int DLD = DMEM_LOG2_DEEP
);
   logic                       host_req_i;
   logic                       host_we_i;
   logic [DLD+THREAD_ID_W-1:0] host_addr_i;
   logic [PDW-1:0]             host_wdata_i;
   logic                       host_gnt_o;
   logic [PDW-1:0]             host_rdata_o;
   logic                       host_rvalid_o;

   modport master (
      output host_req_i, host_we_i, host_addr_i, host_wdata_i,
      input  host_gnt_o, host_rdata_o, host_rvalid_o
   );

   modport slave (
      input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
      output host_gnt_o, host_rdata_o, host_rvalid_o
   );
endinterface

// File: rtl/mem_stage_dmem_sp_ram.sv
// Single-port synchronous data RAM, one access per cycle, 1-cycle read latency.
// Contents are not reset; read data holds until the next read.
module dmem_sp_ram #(
   parameter int DW = 64,
   parameter int AW = 10
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rdata_q       <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// MEM stage + MEM/WB register: pipeline owns the banked data RAM, host port uses idle cycles.
// Latency 1 to WB; host reads respond one cycle after grant.
module mem_stage
   import aurora_pkg::*;
#(
   parameter int PROC_DATA_WIDTH_P        = PROC_DATA_WIDTH,
   parameter int PROC_REGFILE_LOG2_DEEP_P = PROC_REGFILE_LOG2_DEEP,
   parameter int INSTMEM_LOG2_DEEP_P      = INSTMEM_LOG2_DEEP,
   parameter int DMEM_LOG2_DEEP_P         = DMEM_LOG2_DEEP
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                reg_write_en_i,
   input  logic                                mem_write_en_i,
   input  logic                                mem_read_en_i,
   input  logic                                mem_to_reg_i,
   input  logic [PROC_DATA_WIDTH_P-1:0]        alu_i,
   input  logic [PROC_DATA_WIDTH_P-1:0]        reg_data2_i,
   input  logic [PROC_REGFILE_LOG2_DEEP_P-1:0] reg_write_addr_i,
   input  logic [THREAD_ID_W-1:0]              thread_id_i,
   input  logic [INSTMEM_LOG2_DEEP_P-1:0]      pc_carry_baggage_i,
   mem_stage_if.slave                          host,
   output logic                                reg_write_en_o,
   output logic                                mem_to_reg_o,
   output logic [PROC_REGFILE_LOG2_DEEP_P-1:0] reg_write_addr_o,
   output logic [THREAD_ID_W-1:0]              thread_id_o,
   output logic [INSTMEM_LOG2_DEEP_P-1:0]      pc_carry_baggage_o,
   output logic [PROC_DATA_WIDTH_P-1:0]        alu_o,
   output logic [PROC_DATA_WIDTH_P-1:0]        mem_rdata_o
);
   localparam int PDW = PROC_DATA_WIDTH_P;
   localparam int DLD = DMEM_LOG2_DEEP_P;
   localparam int AW  = DLD + THREAD_ID_W;

   host_state_e state_q, state_d;

   logic           pipe_acc;
   logic           host_gnt;
   logic           ram_en, ram_we;
   logic [AW-1:0]  ram_addr;
   logic [PDW-1:0] ram_wdata, ram_rdata;
   logic           pipe_rd_q;
   logic [PDW-1:0] host_rdata_q;

   logic                                reg_write_en_q, mem_to_reg_q;
   logic [PROC_REGFILE_LOG2_DEEP_P-1:0] reg_write_addr_q;
   logic [THREAD_ID_W-1:0]              thread_id_q;
   logic [INSTMEM_LOG2_DEEP_P-1:0]      pc_q;
   logic [PDW-1:0]                      alu_q;

   // Upper address bits are deliberately dropped so accesses wrap inside the thread bank.
   logic unused_alu_hi;
   assign unused_alu_hi = ^alu_i[PDW-1:DLD];

   assign pipe_acc = mem_read_en_i | mem_write_en_i;

   always_comb begin
      state_d  = state_q;
      host_gnt = 1'b0;
      case (state_q)
         HOST_IDLE: begin
            host_gnt = host.host_req_i & ~pipe_acc;
            if (host_gnt && !host.host_we_i) state_d = HOST_RESP;
         end
         HOST_RESP: state_d = HOST_IDLE;
         default:   state_d = HOST_IDLE;
      endcase
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = {thread_id_i, alu_i[DLD-1:0]};
      ram_wdata = reg_data2_i;
      if (pipe_acc) begin
         ram_en = 1'b1;
         ram_we = mem_write_en_i;
      end else if (host_gnt) begin
         ram_en    = 1'b1;
         ram_we    = host.host_we_i;
         ram_addr  = host.host_addr_i;
         ram_wdata = host.host_wdata_i;
      end
   end

   dmem_sp_ram #(.DW(PDW), .AW(AW)) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= HOST_IDLE;
         pipe_rd_q        <= 1'b0;
         host_rdata_q     <= '0;
         reg_write_en_q   <= 1'b0;
         mem_to_reg_q     <= 1'b0;
         reg_write_addr_q <= '0;
         thread_id_q      <= '0;
         pc_q             <= '0;
         alu_q            <= '0;
      end else begin
         state_q          <= state_d;
         // A simultaneous read+write is treated as a write only, so no load data follows.
         pipe_rd_q        <= mem_read_en_i & ~mem_write_en_i;
         if (state_q == HOST_RESP) host_rdata_q <= ram_rdata;
         reg_write_en_q   <= reg_write_en_i;
         mem_to_reg_q     <= mem_to_reg_i;
         reg_write_addr_q <= reg_write_addr_i;
         thread_id_q      <= thread_id_i;
         pc_q             <= pc_carry_baggage_i;
         alu_q            <= alu_i;
      end
   end

   assign host.host_gnt_o    = host_gnt;
   assign host.host_rvalid_o = (state_q == HOST_RESP);
   assign host.host_rdata_o  = (state_q == HOST_RESP) ? ram_rdata : host_rdata_q;

   assign mem_rdata_o        = pipe_rd_q ? ram_rdata : '0;
   assign reg_write_en_o     = reg_write_en_q;
   assign mem_to_reg_o       = mem_to_reg_q;
   assign reg_write_addr_o   = reg_write_addr_q;
   assign thread_id_o        = thread_id_q;
   assign pc_carry_baggage_o = pc_q;
   assign alu_o              = alu_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, store/load, bank wrap, arbitration, host access, illegal r+w.
module tb_mem_stage;
   import aurora_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        reg_write_en_i, mem_write_en_i, mem_read_en_i, mem_to_reg_i;
   logic [63:0] alu_i, reg_data2_i;
   logic [4:0]  reg_write_addr_i;
   logic [1:0]  thread_id_i;
   logic [7:0]  pc_carry_baggage_i;
   logic        reg_write_en_o, mem_to_reg_o;
   logic [4:0]  reg_write_addr_o;
   logic [1:0]  thread_id_o;
   logic [7:0]  pc_carry_baggage_o;
   logic [63:0] alu_o, mem_rdata_o;

   int n_vec  = 0;
   int n_miss = 0;

   mem_stage_if hif ();

   mem_stage dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .reg_write_en_i     (reg_write_en_i),
      .mem_write_en_i     (mem_write_en_i),
      .mem_read_en_i      (mem_read_en_i),
      .mem_to_reg_i       (mem_to_reg_i),
      .alu_i              (alu_i),
      .reg_data2_i        (reg_data2_i),
      .reg_write_addr_i   (reg_write_addr_i),
      .thread_id_i        (thread_id_i),
      .pc_carry_baggage_i (pc_carry_baggage_i),
      .host               (hif.slave),
      .reg_write_en_o     (reg_write_en_o),
      .mem_to_reg_o       (mem_to_reg_o),
      .reg_write_addr_o   (reg_write_addr_o),
      .thread_id_o        (thread_id_o),
      .pc_carry_baggage_o (pc_carry_baggage_o),
      .alu_o              (alu_o),
      .mem_rdata_o        (mem_rdata_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_pipe();
      reg_write_en_i     = 1'b0;
      mem_write_en_i     = 1'b0;
      mem_read_en_i      = 1'b0;
      mem_to_reg_i       = 1'b0;
      alu_i              = '0;
      reg_data2_i        = '0;
      reg_write_addr_i   = '0;
      thread_id_i        = '0;
      pc_carry_baggage_i = '0;
   endtask

   task automatic pipe_op(input logic we, input logic re, input logic [1:0] tid,
                          input logic [63:0] addr, input logic [63:0] data);
      mem_write_en_i = we;
      mem_read_en_i  = re;
      thread_id_i    = tid;
      alu_i          = addr;
      reg_data2_i    = data;
   endtask

   initial begin
      idle_pipe();
      hif.host_req_i   = 1'b0;
      hif.host_we_i    = 1'b0;
      hif.host_addr_i  = '0;
      hif.host_wdata_i = '0;
      tick(); tick();
      rst_ni = 1'b1;

      // 1. async reset mid-cycle
      reg_write_en_i = 1; mem_to_reg_i = 1; reg_write_addr_i = 5'h1F; pc_carry_baggage_i = 8'hC3;
      pipe_op(1, 0, 2'd1, 64'hA5A5_A5A5_A5A5_A5FE, 64'h77);
      hif.host_req_i = 1'b1;
      tick();
      check_val("pre_rst_alu", alu_o, 64'hA5A5_A5A5_A5A5_A5FE);
      check_val("pre_rst_pc", pc_carry_baggage_o, 8'hC3);
      #3 rst_ni = 1'b0;
      #1;
      check_val("rst_alu", alu_o, 0);
      check_val("rst_rwe", reg_write_en_o, 0);
      check_val("rst_m2r", mem_to_reg_o, 0);
      check_val("rst_rwa", reg_write_addr_o, 0);
      check_val("rst_tid", thread_id_o, 0);
      check_val("rst_pc", pc_carry_baggage_o, 0);
      check_val("rst_rdata", mem_rdata_o, 0);
      check_val("rst_rvalid", hif.host_rvalid_o, 0);
      check_val("rst_hrdata", hif.host_rdata_o, 0);
      idle_pipe();
      hif.host_req_i = 1'b0;
      tick();
      rst_ni = 1'b1;

      // 2. store then load, bank isolation
      pipe_op(1, 0, 2'd1, 64'd5, 64'h1111); tick();
      pipe_op(1, 0, 2'd2, 64'd5, 64'hDEADBEEF); tick();
      pipe_op(0, 1, 2'd2, 64'd5, 64'h0); tick();
      check_val("ld_t2_i5", mem_rdata_o, 64'hDEADBEEF);
      check_val("ld_alu_o", alu_o, 64'd5);
      check_val("ld_tid_o", thread_id_o, 2'd2);
      pipe_op(0, 1, 2'd1, 64'd5, 64'h0); tick();
      check_val("ld_t1_i5", mem_rdata_o, 64'h1111);
      idle_pipe(); tick();
      check_val("no_rd_zero", mem_rdata_o, 0);

      // 3. wrap within bank
      pipe_op(1, 0, 2'd0, 64'h105, 64'hCAFE0105); tick();
      pipe_op(0, 1, 2'd0, 64'h005, 64'h0); tick();
      check_val("wrap_ld", mem_rdata_o, 64'hCAFE0105);

      // 4. arbitration: host write {3,7} waits for three loads
      hif.host_req_i = 1'b1; hif.host_we_i = 1'b1;
      hif.host_addr_i = 10'h307; hif.host_wdata_i = 64'h1234;
      for (int i = 0; i < 3; i++) begin
         pipe_op(0, 1, 2'd0, 64'd5, 64'h0);
         #1 check_val($sformatf("arb_gnt_busy%0d", i), hif.host_gnt_o, 0);
         tick();
      end
      idle_pipe();
      #1 check_val("arb_gnt_idle", hif.host_gnt_o, 1);
      tick();
      hif.host_req_i = 1'b0;
      check_val("wr_no_rvalid", hif.host_rvalid_o, 0);

      // 5. host read {3,7}
      hif.host_req_i = 1'b1; hif.host_we_i = 1'b0;
      #1 check_val("hrd_gnt", hif.host_gnt_o, 1);
      tick();
      check_val("hrd_rvalid", hif.host_rvalid_o, 1);
      check_val("hrd_rdata", hif.host_rdata_o, 64'h1234);
      check_val("resp_no_gnt", hif.host_gnt_o, 0);
      hif.host_req_i = 1'b0;
      tick();
      check_val("hrd_pulse_end", hif.host_rvalid_o, 0);
      check_val("hrd_hold", hif.host_rdata_o, 64'h1234);
      pipe_op(0, 1, 2'd3, 64'd7, 64'h0); tick();
      check_val("pipe_sees_host", mem_rdata_o, 64'h1234);

      // 6. illegal read+write
      pipe_op(1, 1, 2'd1, 64'd9, 64'hAA); reg_write_addr_i = 5'd17; tick();
      check_val("illegal_rdata", mem_rdata_o, 0);
      check_val("illegal_rwa", reg_write_addr_o, 5'd17);
      check_val("illegal_tid", thread_id_o, 2'd1);
      pipe_op(0, 1, 2'd1, 64'd9, 64'h0); reg_write_addr_i = 5'd3; tick();
      check_val("illegal_wr_done", mem_rdata_o, 64'hAA);
      check_val("rwa_follow", reg_write_addr_o, 5'd3);

      // reset during a granted host read drops the response
      idle_pipe();
      hif.host_req_i = 1'b1; hif.host_we_i = 1'b0; hif.host_addr_i = 10'h307;
      #1 check_val("rst_rd_gnt", hif.host_gnt_o, 1);
      #1 rst_ni = 1'b0;
      hif.host_req_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      check_val("rst_rd_dropped", hif.host_rvalid_o, 0);
      tick();
      check_val("rst_rd_dropped2", hif.host_rvalid_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
